// File: rtl/udp_loop_buf.sv
// udp_loop_buf: UDP payload loopback buffer.
// Stores one received payload in a byte RAM, then replays it to the UDP
// transmitter on request. Packets that arrive while a replay is in
// progress, that overflow the buffer, or that are empty are dropped and counted.
//
// Ports:
//   gmii_clk      single 125 MHz clock, rising edge
//   rst_n         asynchronous active-low reset
//   rec_en        received payload byte valid
//   rec_data      received payload byte
//   rec_pkt_done  received packet complete (pulse)
//   rec_byte_num  receiver's payload length (not used; the stored count wins)
//   tx_req        transmitter requests next payload byte
//   tx_done       transmitter finished frame (pulse)
//   tx_start_en   start-transmit pulse
//   tx_byte_num   payload length to transmit
//   tx_data       payload byte to transmitter (one cycle after tx_req)
//   busy          replay in progress (START/SEND/WAIT_DONE)
//   drop_cnt      saturating count of discarded packets
//   timeout_err   sticky: tx_done never arrived within TIMEOUT cycles
module udp_loop_buf #(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 65535
) (
  input  logic        gmii_clk,
  input  logic        rst_n,
  input  logic        rec_en,
  input  logic [7:0]  rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic        timeout_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RECV, START, SEND, WAIT_DONE} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W:0]   wcnt;
  logic [ADDR_W:0]   rptr;
  logic              ovf;
  logic [TW-1:0]     tmr;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wcnt_full;
  logic [ADDR_W:0]   wcnt_nx;
  logic              ovf_nx;
  logic              drop_evt;
  logic              unused_rec_byte_num;

  assign unused_rec_byte_num = ^rec_byte_num;

  // wcnt can only reach DEPTH, so its top bit alone marks a full buffer
  assign wcnt_full = wcnt[ADDR_W];

  // Byte count and overflow flag including this cycle's rec_en, so a byte
  // arriving together with rec_pkt_done is part of the closed packet.
  always_comb begin
    wcnt_nx = wcnt;
    ovf_nx  = ovf;
    if (state == RECV && rec_en) begin
      if (wcnt_full) ovf_nx  = 1'b1;
      else           wcnt_nx = wcnt + (ADDR_W+1)'(1);
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wcnt[ADDR_W-1:0];
    if (state == IDLE && rec_en) begin
      wr_en   = 1'b1;
      wr_addr = '0;
    end else if (state == RECV && rec_en && !wcnt_full) begin
      wr_en   = 1'b1;
    end
  end

  always_comb begin
    drop_evt = 1'b0;
    if (rec_pkt_done) begin
      case (state)
        IDLE:    drop_evt = !rec_en;
        RECV:    drop_evt = ovf_nx || (wcnt_nx == '0);
        default: drop_evt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge gmii_clk) begin
    if (wr_en) mem[wr_addr] <= rec_data;
  end

  always_ff @(posedge gmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      rptr        <= '0;
      ovf         <= 1'b0;
      tmr         <= '0;
      tx_start_en <= 1'b0;
      tx_byte_num <= '0;
      tx_data     <= '0;
      busy        <= 1'b0;
      drop_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_start_en <= 1'b0;
      if (drop_evt && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (rec_en) begin
            wcnt <= (ADDR_W+1)'(1);
            if (rec_pkt_done) begin
              tx_byte_num <= 16'd1;
              tx_start_en <= 1'b1;
              busy        <= 1'b1;
              state       <= START;
            end else begin
              state       <= RECV;
            end
          end
        end

        RECV: begin
          wcnt <= wcnt_nx;
          ovf  <= ovf_nx;
          if (rec_pkt_done) begin
            if (ovf_nx || wcnt_nx == '0) begin
              state <= IDLE;
              wcnt  <= '0;
              ovf   <= 1'b0;
            end else begin
              tx_byte_num <= 16'(wcnt_nx);
              tx_start_en <= 1'b1;
              busy        <= 1'b1;
              state       <= START;
            end
          end
        end

        START: begin
          rptr  <= '0;
          state <= SEND;
        end

        SEND: begin
          // rptr < tx_byte_num throughout SEND; the last serve moves to WAIT_DONE
          if (tx_req) begin
            tx_data <= mem[rptr[ADDR_W-1:0]];
            rptr    <= rptr + (ADDR_W+1)'(1);
          end
          if (tx_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            wcnt  <= '0;
            ovf   <= 1'b0;
          end else if (tx_req && (16'(rptr) + 16'd1 == tx_byte_num)) begin
            tmr   <= '0;
            state <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (tx_done || tmr == TW'(TIMEOUT - 1)) begin
            if (!tx_done) timeout_err <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
            wcnt  <= '0;
            ovf   <= 1'b0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/udp_loop_buf.md
UDP_LOOP_BUF -- requirements
Module: udp_loop_buf

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning log2 of payload buffer depth (DEPTH = 2048 bytes).
REQ-002 The block SHALL have parameter TIMEOUT, default 65535, meaning max cycles waited in WAIT_DONE for tx_done.
REQ-003 Ports SHALL be exactly as follows, one per line: name, direction, width, meaning.
- gmii_clk  input  1  single clock (125 MHz GMII clock); all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rec_en  input  1  received payload byte valid
- rec_data  input  8  received payload byte
- rec_pkt_done  input  1  one-cycle pulse: received packet complete
- rec_byte_num  input  16  payload length reported by receiver, valid with rec_pkt_done
- tx_req  input  1  UDP transmitter requests next payload byte
- tx_done  input  1  one-cycle pulse: UDP transmitter finished frame
- tx_start_en  output  1  one-cycle pulse: start transmit
- tx_byte_num  output  16  payload length to transmit, stable from tx_start_en until tx_done
- tx_data  output  8  payload byte to transmitter
- busy  output  1  high whenever state is not IDLE or RECV
- drop_cnt  output  8  saturating count of discarded received packets
- timeout_err  output  1  sticky: tx_done not seen within TIMEOUT cycles

Function
REQ-004 Storage SHALL be a single-port-write/single-port-read byte RAM of DEPTH entries with registered read data.
REQ-005 States SHALL be IDLE, RECV, START, SEND, WAIT_DONE.
REQ-006 IDLE -> RECV on the first rec_en; that byte is written at address 0; write counter wcnt becomes 1.
REQ-007 In RECV, each rec_en writes rec_data at address wcnt and increments wcnt, while wcnt < DEPTH.
REQ-008 rec_en with wcnt == DEPTH SHALL discard the byte and set the internal ovf flag.
REQ-009 rec_en and rec_pkt_done in the same cycle: the byte SHALL be stored before the packet is closed.
REQ-010 On rec_pkt_done in RECV: if ovf set or wcnt == 0 -> drop packet (drop_cnt+1), go IDLE; else latch tx_byte_num = wcnt, go START.
REQ-011 rec_pkt_done in IDLE with no prior rec_en (zero-length packet) SHALL be counted as dropped; state stays IDLE.
REQ-012 tx_byte_num SHALL be the stored byte count, not rec_byte_num; if they differ, the mismatch is ignored.
REQ-013 START SHALL assert tx_start_en for exactly one cycle, reset read pointer rptr to 0, then go SEND.
REQ-014 In SEND, tx_req high in cycle N SHALL cause tx_data in cycle N+1 to be byte rptr; rptr then increments.
REQ-015 After tx_byte_num bytes have been served, further tx_req SHALL hold tx_data at the last byte with rptr frozen.
REQ-016 SEND -> WAIT_DONE when rptr reaches tx_byte_num; tx_done seen in SEND or WAIT_DONE -> IDLE.
REQ-017 In WAIT_DONE, a cycle counter SHALL run; reaching TIMEOUT -> set timeout_err, go IDLE.
REQ-018 rec_en/rec_pkt_done during START, SEND or WAIT_DONE SHALL be ignored; each rec_pkt_done there increments drop_cnt.
REQ-019 drop_cnt SHALL saturate at 255 and never wrap.
REQ-020 On returning to IDLE, wcnt and ovf SHALL clear; tx_byte_num SHALL hold its last value.

Reset
REQ-021 While rst_n is low: state IDLE, tx_start_en 0, tx_byte_num 0, tx_data 0, busy 0, drop_cnt 0, timeout_err 0, wcnt/rptr/ovf cleared.
REQ-022 Reset asserted mid-RECV or mid-SEND SHALL abandon the packet; no tx_start_en after release until a new complete packet arrives.
REQ-023 RAM contents need not be cleared by reset.

Verification
REQ-024 10 bytes 00,11,...,99 then rec_pkt_done -> one tx_start_en, tx_byte_num=10, tx_data sequence 00..99 one cycle after each tx_req; tx_done -> busy=0.
REQ-025 Packet of 30 bytes while a 10-byte packet is in SEND -> second packet dropped, drop_cnt=1, first packet transmitted intact.
REQ-026 2049 bytes then rec_pkt_done -> no tx_start_en, drop_cnt=1; next 4-byte packet transmits with tx_byte_num=4.
REQ-027 rec_pkt_done with no rec_en -> drop_cnt=1, no tx_start_en; 300 such events -> drop_cnt=255.
REQ-028 TIMEOUT=100, 5-byte packet, tx_done withheld -> timeout_err=1 about 100 cycles after last byte, state IDLE.
REQ-029 rst_n low for 1 cycle during SEND of 30-byte packet -> all outputs 0, no further tx_start_en until a new packet completes.
